// File: rtl/window_sequencer.sv
// window_sequencer
// Frame-level controller around a sliding-window line buffer. It accepts one
// raster-ordered frame of pixels from upstream, forwards them (registered) to
// the line buffer, counts the buffer's window-valid pulses to detect the end
// of the frame, applies the vertical stride to those pulses and tracks the
// output coordinates of each surviving window.
module window_sequencer #(
  parameter int KER_SIZE = 3,
  parameter int BITWIDTH = 8,
  parameter int NFMAPS   = 3,
  parameter int STRIDE   = 1,
  parameter int NW       = 32,
  parameter int NH       = 32,
  localparam int WPR = (NW - KER_SIZE) / STRIDE + 1,
  localparam int WPC = (NH - KER_SIZE) / STRIDE + 1,
  localparam int TOT = (NH - KER_SIZE + 1) * WPR,
  localparam int CW  = $clog2(NW),
  localparam int RW  = $clog2(NH),
  localparam int DW  = NFMAPS * BITWIDTH
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          buf_valid,
  output logic          buf_flush,
  output logic [DW-1:0] buf_D,
  input  logic          buf_ready,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  // Counter widths: each counter holds exactly its largest value.
  localparam int TW = $clog2(TOT + 1);
  localparam int PW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  // Terminal values, pre-sized to the counters they are compared against.
  localparam logic [CW-1:0] PIX_COL_LAST = CW'(NW - 1);
  localparam logic [RW-1:0] PIX_ROW_LAST = RW'(NH - 1);
  localparam logic [TW-1:0] WIN_TOTAL    = TW'(TOT);
  localparam logic [PW-1:0] WPR_LAST     = PW'(WPR - 1);
  localparam logic [SW-1:0] PHASE_LAST   = SW'(STRIDE - 1);
  localparam logic [CW-1:0] WIN_COL_LAST = CW'(WPR - 1);
  // One past the last output row; the row counter parks here after the
  // final window so stray pulses can never wrap it.
  localparam logic [RW-1:0] WIN_ROW_END  = RW'(WPC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_DRAIN = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_aborted;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_buf_flush;
  logic          r_frame_done;
  logic          r_err;

  logic [CW-1:0] r_pix_col;
  logic [RW-1:0] r_pix_row;

  logic          r_buf_valid;
  logic [DW-1:0] r_buf_d;

  logic [TW-1:0] r_win_cnt;
  logic [PW-1:0] r_wpr_cnt;
  logic [SW-1:0] r_phase;

  logic [CW-1:0] r_win_col;
  logic [RW-1:0] r_win_row;

  logic          w_accept;
  logic          w_active;
  logic          w_start_ok;
  logic          w_last_pix;
  logic          w_win_pulse;
  logic          w_win_valid;
  logic          w_stray_ready;

  assign w_accept      = in_valid && r_in_ready;
  assign w_active      = (r_state == S_FILL) || (r_state == S_DRAIN);
  assign w_start_ok    = start && (r_state == S_IDLE);
  assign w_last_pix    = w_accept && (r_pix_col == PIX_COL_LAST) && (r_pix_row == PIX_ROW_LAST);
  // Every buffer window seen while a frame is live, before vertical striding.
  assign w_win_pulse   = buf_ready && w_active;
  // Only windows on rows that are a multiple of the stride survive.
  assign w_win_valid   = w_win_pulse && (r_phase == '0);
  // A window pulse with no frame in flight means the buffer is out of step.
  assign w_stray_ready = buf_ready &&
                         ((r_state == S_IDLE) || (r_state == S_FLUSH) || (r_state == S_DONE));

  // Frame FSM; status outputs are registered alongside the state so they
  // always agree with it cycle for cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_aborted    <= 1'b0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_buf_flush  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // start beats a simultaneous abort simply because abort is not
          // looked at in this state.
          if (start) begin
            r_state    <= S_FILL;
            r_aborted  <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FILL: begin
          if (abort) begin
            r_state     <= S_FLUSH;
            r_aborted   <= 1'b1;
            r_in_ready  <= 1'b0;
            r_buf_flush <= 1'b1;
          end else if (w_last_pix) begin
            // Always pass through DRAIN, even if every window has already
            // been counted; DRAIN then leaves on its first cycle.
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state     <= S_FLUSH;
            r_aborted   <= 1'b1;
            r_buf_flush <= 1'b1;
          end else if (r_win_cnt == WIN_TOTAL) begin
            r_state     <= S_FLUSH;
            r_buf_flush <= 1'b1;
          end
        end
        S_FLUSH: begin
          // An aborted frame returns straight to IDLE with no done pulse.
          r_buf_flush <= 1'b0;
          r_busy      <= 1'b0;
          r_aborted   <= 1'b0;
          if (r_aborted) begin
            r_state <= S_IDLE;
          end else begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_frame_done <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_aborted    <= 1'b0;
          r_in_ready   <= 1'b0;
          r_busy       <= 1'b0;
          r_buf_flush  <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pix_col <= '0;
      r_pix_row <= '0;
    end else if (w_start_ok) begin
      r_pix_col <= '0;
      r_pix_row <= '0;
    end else if (w_accept) begin
      if (r_pix_col == PIX_COL_LAST) begin
        r_pix_col <= '0;
        r_pix_row <= (r_pix_row == PIX_ROW_LAST) ? '0 : r_pix_row + 1'b1;
      end else begin
        r_pix_col <= r_pix_col + 1'b1;
      end
    end
  end

  // Pixel path to the line buffer: one register stage; data holds when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf_valid <= 1'b0;
      r_buf_d     <= '0;
    end else begin
      r_buf_valid <= w_accept;
      if (w_accept) begin
        r_buf_d <= in_data;
      end
    end
  end

  // Buffer-window bookkeeping: total count for end-of-frame detection, and
  // position within the current window row to derive the vertical phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win_cnt <= '0;
      r_wpr_cnt <= '0;
      r_phase   <= '0;
    end else if (w_start_ok) begin
      r_win_cnt <= '0;
      r_wpr_cnt <= '0;
      r_phase   <= '0;
    end else if (w_win_pulse) begin
      if (r_win_cnt != WIN_TOTAL) begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end
      if (r_wpr_cnt == WPR_LAST) begin
        r_wpr_cnt <= '0;
        r_phase   <= (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
      end else begin
        r_wpr_cnt <= r_wpr_cnt + 1'b1;
      end
    end
  end

  // Output-grid coordinates of the current (or next expected) window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win_col <= '0;
      r_win_row <= '0;
    end else if (w_start_ok) begin
      r_win_col <= '0;
      r_win_row <= '0;
    end else if (w_win_valid) begin
      if (r_win_col == WIN_COL_LAST) begin
        r_win_col <= '0;
        if (r_win_row != WIN_ROW_END) begin
          r_win_row <= r_win_row + 1'b1;
        end
      end else begin
        r_win_col <= r_win_col + 1'b1;
      end
    end
  end

  // Sticky error flag; a stray pulse in the same cycle as start still flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_stray_ready) begin
      r_err <= 1'b1;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end
  end

  assign in_ready   = r_in_ready;
  assign buf_valid  = r_buf_valid;
  assign buf_flush  = r_buf_flush;
  assign buf_D      = r_buf_d;
  assign win_valid  = w_win_valid;
  assign win_col    = r_win_col;
  assign win_row    = r_win_row;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule

// File: tb/tb_window_sequencer.sv
// Bench for window_sequencer: a behavioural line-buffer model turns the
// forwarded pixel stream into window-valid pulses, and each frame's observed
// windows are compared with the output grid computed from the frame geometry.
module tb_window_sequencer;

  localparam int K    = 3;
  localparam int BW   = 8;
  localparam int NF   = 3;
  localparam int S    = 2;
  localparam int NW   = 8;
  localparam int NH   = 7;
  localparam int DW   = NF * BW;
  localparam int CW   = $clog2(NW);
  localparam int RW   = $clog2(NH);
  localparam int WPR  = (NW - K) / S + 1;
  localparam int WPC  = (NH - K) / S + 1;
  localparam int TOT  = (NH - K + 1) * WPR;
  localparam int NPIX = NW * NH;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          buf_valid;
  logic          buf_flush;
  logic [DW-1:0] buf_D;
  logic          buf_ready;
  logic          win_valid;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          busy;
  logic          frame_done;
  logic          err;

  logic          lb_ready;
  logic          inj_ready = 1'b0;
  int            lb_idx;

  int errors = 0;
  int checks = 0;

  // Per-frame observations filled in by run_frame.
  int   n_acc, n_bufrdy, n_done, n_flush, flush_cyc, done_cyc;
  logic ir_after_abort, fl_after_abort, err_at_start;
  int   obs_col[$];
  int   obs_row[$];

  always #5 clk = ~clk;

  assign buf_ready = lb_ready | inj_ready;

  window_sequencer #(
    .KER_SIZE(K), .BITWIDTH(BW), .NFMAPS(NF), .STRIDE(S), .NW(NW), .NH(NH)
  ) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .buf_valid(buf_valid), .buf_flush(buf_flush), .buf_D(buf_D),
    .buf_ready(buf_ready), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  // Line-buffer model: one cycle after the pixel at (x,y) arrives, pulse if a
  // full kernel ends there and x lies on the column-stride grid.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lb_ready <= 1'b0;
      lb_idx   <= 0;
    end else begin
      lb_ready <= 1'b0;
      if (buf_flush) begin
        lb_idx <= 0;
      end else if (buf_valid) begin
        lb_ready <= ((lb_idx % NW) >= K - 1) && ((lb_idx / NW) >= K - 1) &&
                    ((((lb_idx % NW) - (K - 1)) % S) == 0);
        lb_idx   <= lb_idx + 1;
      end
    end
  end

  // One frame: start pulse, pixels offered with probability prob%, optional
  // abort once abort_at pixels are in, optional stray start mid-frame.
  task automatic run_frame(input int prob, input int abort_at, input bit poke_start);
    logic          acc_prev;
    logic [DW-1:0] d_prev;
    bit            fin;
    n_acc = 0; n_bufrdy = 0; n_done = 0; n_flush = 0;
    flush_cyc = -1; done_cyc = -2;
    ir_after_abort = 1'b1; fl_after_abort = 1'b0;
    obs_col.delete(); obs_row.delete();
    acc_prev = 1'b0; d_prev = '0; fin = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    err_at_start = err;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      checks++;
      if (buf_valid !== acc_prev) begin
        errors++;
        $display("FAIL buf_valid_mirror: cycle %0d got %b expected %b", cyc, buf_valid, acc_prev);
      end
      if (acc_prev) begin
        checks++;
        if (buf_D !== d_prev) begin
          errors++;
          $display("FAIL buf_D_data: cycle %0d got %h expected %h", cyc, buf_D, d_prev);
        end
      end
      if (win_valid === 1'b1) begin
        obs_col.push_back(int'(win_col));
        obs_row.push_back(int'(win_row));
      end
      if (buf_ready === 1'b1) n_bufrdy++;
      if (buf_flush === 1'b1) begin n_flush++; flush_cyc = cyc; end
      if (frame_done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (abort) begin ir_after_abort = in_ready; fl_after_abort = buf_flush; end
      if (n_flush > 0 && buf_flush === 1'b0 && busy === 1'b0) fin = 1'b1;
      if (!fin) begin
        in_valid = ($urandom_range(99) < prob);
        in_data  = DW'($urandom);
        acc_prev = in_valid && in_ready;
        d_prev   = in_data;
        if (acc_prev) n_acc++;
        abort = (abort_at > 0) && acc_prev && (n_acc == abort_at);
        start = poke_start && acc_prev && (n_acc == NPIX / 2);
        @(negedge clk);
      end
    end
    in_valid = 1'b0; abort = 1'b0; start = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL frame_timeout: got no end of frame, expected one within 3000 cycles");
    end
    if (abort_at == 0) begin
      checks++;
      if (n_acc != NPIX) begin
        errors++; $display("FAIL pixels_accepted: got %0d expected %0d", n_acc, NPIX);
      end
      checks++;
      if (n_bufrdy != TOT) begin
        errors++; $display("FAIL buf_ready_count: got %0d expected %0d", n_bufrdy, TOT);
      end
      checks++;
      if (obs_col.size() != WPR * WPC) begin
        errors++; $display("FAIL win_valid_count: got %0d expected %0d", obs_col.size(), WPR * WPC);
      end
      for (int r = 0; r < WPC; r++) begin
        for (int c = 0; c < WPR; c++) begin
          if (r * WPR + c < obs_col.size()) begin
            checks++;
            if (obs_col[r * WPR + c] != c || obs_row[r * WPR + c] != r) begin
              errors++;
              $display("FAIL win_coord[%0d]: got (%0d,%0d) expected (%0d,%0d)", r * WPR + c,
                       obs_col[r * WPR + c], obs_row[r * WPR + c], c, r);
            end
          end
        end
      end
      checks++;
      if (n_done != 1 || n_flush != 1) begin
        errors++; $display("FAIL done_flush_pulses: got done=%0d flush=%0d expected 1 and 1", n_done, n_flush);
      end
      checks++;
      if (done_cyc != flush_cyc + 1) begin
        errors++; $display("FAIL flush_then_done: got done at %0d flush at %0d expected done one cycle after flush",
                           done_cyc, flush_cyc);
      end
      checks++;
      if (err_at_start !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL err_in_frame: got start=%b end=%b expected 0 and 0", err_at_start, err);
      end
    end
    $display("frame: prob=%0d abort_at=%0d accepted=%0d buf_ready=%0d windows=%0d done=%0d flush=%0d",
             prob, abort_at, n_acc, n_bufrdy, obs_col.size(), n_done, n_flush);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, buf_valid, buf_flush, win_valid, busy, frame_done, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {in_ready, buf_valid, buf_flush, win_valid, busy, frame_done, err});
    end
    checks++;
    if (buf_D !== '0 || win_col !== '0 || win_row !== '0) begin
      errors++; $display("FAIL reset_data: got D=%h col=%0d row=%0d expected zeros", buf_D, win_col, win_row);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b in_ready=%b expected 0 0", busy, in_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_full_frame();
    run_frame(100, 0, 1'b0);
  endtask

  task automatic test_random_valid();
    run_frame(50, 0, 1'b0);
    run_frame(25, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_frame(100, 20, 1'b0);
    checks++;
    if (n_acc != 20) begin
      errors++; $display("FAIL abort_pixels: got %0d expected 20", n_acc);
    end
    checks++;
    if (ir_after_abort !== 1'b0 || fl_after_abort !== 1'b1) begin
      errors++; $display("FAIL abort_response: got in_ready=%b flush=%b expected 0 1", ir_after_abort, fl_after_abort);
    end
    checks++;
    if (n_flush != 1 || n_done != 0) begin
      errors++; $display("FAIL abort_pulses: got flush=%0d done=%0d expected 1 0", n_flush, n_done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b expected 0", busy);
    end
    run_frame(100, 0, 1'b0);
  endtask

  task automatic test_err_inject();
    @(negedge clk); inj_ready = 1'b1;
    #1;
    checks++;
    if (win_valid !== 1'b0) begin
      errors++; $display("FAIL idle_win_valid: got %b expected 0", win_valid);
    end
    @(negedge clk); inj_ready = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_set: got %b expected 1", err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b expected 1", err);
    end
    run_frame(100, 0, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || buf_flush !== 1'b0) begin
      errors++; $display("FAIL idle_abort_ignored: got busy=%b flush=%b expected 0 0", busy, buf_flush);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL start_beats_abort: got busy=%b in_ready=%b expected 1 1", busy, in_ready);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (buf_flush !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL empty_abort: got flush=%b in_ready=%b expected 1 0", buf_flush, in_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL empty_abort_idle: got busy=%b done=%b expected 0 0", busy, frame_done);
    end
    $display("start/abort: done");
  endtask

  task automatic test_back_to_back();
    run_frame(100, 0, 1'b1);
    run_frame(70, 0, 1'b0);
  endtask

  task automatic test_reset_in_drain();
    bit reached;
    reached = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 200 && !reached; i++) begin
      in_data = DW'($urandom);
      @(negedge clk);
      if (in_ready === 1'b0) reached = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (!reached || busy !== 1'b1 || buf_flush !== 1'b0) begin
      errors++; $display("FAIL reach_drain: got reached=%b busy=%b flush=%b expected 1 1 0", reached, busy, buf_flush);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({in_ready, buf_valid, buf_flush, win_valid, busy, frame_done, err} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_flags: got %b expected 0000000",
               {in_ready, buf_valid, buf_flush, win_valid, busy, frame_done, err});
    end
    checks++;
    if (buf_D !== '0 || win_col !== '0 || win_row !== '0) begin
      errors++; $display("FAIL async_reset_data: got D=%h col=%0d row=%0d expected zeros", buf_D, win_col, win_row);
    end
    @(negedge clk);
    checks++;
    if (buf_flush !== 1'b0) begin
      errors++; $display("FAIL reset_no_flush: got %b expected 0", buf_flush);
    end
    rstn = 1'b1;
    @(negedge clk);
    run_frame(100, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_valid();
    test_abort();
    test_err_inject();
    test_start_abort_idle();
    test_back_to_back();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/window_sequencer.md
WINDOW_SEQUENCER -- requirements
Module: window_sequencer

Interface
REQ-001 Parameter KER_SIZE, default 3, kernel edge in pixels; legal values 2, 3, 5.
REQ-002 Parameter BITWIDTH, default 8, bits per pixel per feature map.
REQ-003 Parameter NFMAPS, default 3, feature maps carried in parallel per pixel.
REQ-004 Parameter STRIDE, default 1, window stride in both x and y; legal range 1..7.
REQ-005 Parameter NW, default 32, input frame width in pixels; NW >= KER_SIZE.
REQ-006 Parameter NH, default 32, input frame height in pixels; NH >= KER_SIZE.
REQ-007 Derived: WPR = (NW-KER_SIZE)/STRIDE+1; WPC = (NH-KER_SIZE)/STRIDE+1; TOT = (NH-KER_SIZE+1)*WPR; CW = $clog2(NW); RW = $clog2(NH).
REQ-008 clk  input  1  single clock, rising edge.
REQ-009 rstn  input  1  reset; asynchronous assertion; active low.
REQ-010 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-011 abort  input  1  one-cycle pulse that terminates the current frame.
REQ-012 in_valid / in_ready  input / output  1 / 1  upstream pixel handshake, raster order.
REQ-013 in_data  input  NFMAPS*BITWIDTH  upstream pixel.
REQ-014 buf_valid, buf_flush  output  1, 1  drive the line-buffer valid and flush inputs.
REQ-015 buf_D  output  NFMAPS*BITWIDTH  drives the line-buffer pixel input.
REQ-016 buf_ready  input  1  line-buffer window-valid pulse; column stride is already applied.
REQ-017 win_valid  output  1  window accepted after vertical-stride gating.
REQ-018 win_col, win_row  output  CW, RW  output coordinates of the current window.
REQ-019 busy, frame_done, err  output  1, 1, 1  state indicators.

Function
REQ-020 FSM states: IDLE, FILL, DRAIN, FLUSH, DONE; encoding is implementation choice.
REQ-021 Transitions: IDLE->FILL on start; FILL->DRAIN once pixel NW*NH-1 is accepted; DRAIN->FLUSH when the buf_ready count reaches TOT; FLUSH->DONE after 1 cycle; DONE->IDLE after 1 cycle.
REQ-022 abort in FILL or DRAIN: next state FLUSH, then IDLE, skipping DONE; no frame_done pulse; abort in IDLE, FLUSH or DONE is ignored.
REQ-023 in_ready = 1 only in FILL; a pixel is accepted when in_valid && in_ready.
REQ-024 Pixel column counter runs 0..NW-1 and wraps to 0, incrementing the row counter 0..NH-1; both counters clear on entry to FILL.
REQ-025 buf_valid and buf_D are registered: 1-cycle latency from acceptance; buf_valid = 0 when no pixel is accepted, and buf_D holds its last value.
REQ-026 buf_flush = 1 exactly in the FLUSH state, otherwise 0.
REQ-027 Buffer window counter counts buf_ready pulses in FILL/DRAIN; window row phase counter runs 0..STRIDE-1 and advances every WPR buf_ready pulses.
REQ-028 win_valid = buf_ready && phase==0 && state in {FILL, DRAIN}; combinational, same cycle as buf_ready.
REQ-029 win_col increments on each win_valid and wraps at WPR-1 to 0, incrementing win_row; win_col/win_row show the coordinates of the current/next window and clear on start.
REQ-030 busy = 1 in FILL, DRAIN, FLUSH; frame_done = 1 for exactly the DONE cycle.
REQ-031 err is sticky: set by buf_ready in IDLE, FLUSH or DONE; cleared on an accepted start.
REQ-032 start while not IDLE is ignored; start coincident with abort in IDLE: start wins.
REQ-033 A buf_ready in the same cycle as the final accepted pixel counts normally; DRAIN is entered even if TOT is already reached, and exits on the next cycle.
REQ-034 All counters are sized for their maximum value with no overflow; the TOT counter width is $clog2(TOT+1).

Reset
REQ-035 On rstn low: state IDLE; in_ready, buf_valid, buf_flush, win_valid, busy, frame_done, err = 0; buf_D, win_col, win_row and all counters = 0.
REQ-036 Reset mid-frame returns to IDLE immediately, with no buf_flush pulse.

Verification
REQ-037 K=3, S=1, NW=8, NH=6, in_valid held high, line-buffer model attached -> 48 pixels accepted, 24 win_valid, last at (win_col=5, win_row=3), frame_done once.
REQ-038 K=3, S=2, NW=8, NH=7 -> 15 buf_ready pulses, 9 win_valid (rows 0..2, cols 0..2), buf_flush 1 cycle before frame_done.
REQ-039 Same as REQ-037 with in_valid randomly low 50% of the time -> identical win_valid count and coordinates, and buf_valid exactly mirrors accepted pixels delayed by 1 cycle.
REQ-040 abort after 20 pixels -> in_ready drops the next cycle, buf_flush=1 for 1 cycle, IDLE, no frame_done; the next frame completes normally.
REQ-041 buf_ready injected in IDLE -> err=1, win_valid=0; next start clears err.
REQ-042 rstn asserted during DRAIN -> all outputs 0 asynchronously; after release, a start produces a correct full frame.
